// File: rtl/connect_four_pkg.sv
// Shared Connect-Four types: line direction codes, player codes, board size, sequencer states.
// Types only; no latency and no backpressure.
package connect_four_pkg;

    localparam int DEF_ROWS = 6;
    localparam int DEF_COLS = 7;

    typedef enum logic [3:0] {
        DIR_NONE         = 4'd0,
        DOWN             = 4'd1,
        ROW_1            = 4'd2,
        ROW_2            = 4'd3,
        ROW_3            = 4'd4,
        ROW_4            = 4'd5,
        DIAG_RIGHT_UP_1  = 4'd6,
        DIAG_RIGHT_UP_2  = 4'd7,
        DIAG_RIGHT_UP_3  = 4'd8,
        DIAG_RIGHT_UP_4  = 4'd9,
        DIAG_LEFT_DOWN_1 = 4'd10,
        DIAG_LEFT_DOWN_2 = 4'd11,
        DIAG_LEFT_DOWN_3 = 4'd12,
        DIAG_LEFT_DOWN_4 = 4'd13
    } dir_e;

    localparam logic [3:0] DIR_FIRST = 4'd1;
    localparam logic [3:0] DIR_LAST  = 4'd13;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        P1    = 2'd1,
        P2    = 2'd2
    } player_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        START  = 3'd2,
        WAIT   = 3'd3,
        DONE   = 3'd4
    } seq_state_e;

endpackage

// File: rtl/win_check_sequencer_if.sv
// Start/finish link between the win-check sequencer and the direction checker.
// Single-cycle start pulse; checker answers with a finished pulse, no other backpressure.
interface win_check_sequencer_if;
    logic       dc_start;
    logic [2:0] dc_row;
    logic [2:0] dc_col;
    logic [3:0] dc_direction;
    logic       dc_finished;
    logic [1:0] dc_winner;

    modport master (
        output dc_start, dc_row, dc_col, dc_direction,
        input  dc_finished, dc_winner
    );

    modport slave (
        input  dc_start, dc_row, dc_col, dc_direction,
        output dc_finished, dc_winner
    );
endinterface

// File: rtl/direction_in_bounds.sv
// Decides whether all four cells of a line direction through (row,col) lie on the board.
// Purely combinational, zero latency, no backpressure.
module direction_in_bounds
    import connect_four_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS
) (
    input  logic [2:0] row,
    input  logic [2:0] col,
    input  logic [3:0] direction,
    output logic       valid
);

    localparam logic [4:0] ROWS_W = 5'(ROWS);
    localparam logic [4:0] COLS_W = 5'(COLS);

    logic [4:0] r;
    logic [4:0] c;
    logic [4:0] d;
    logic [4:0] k;

    // Inequalities are rearranged so nothing is subtracted from r or c;
    // 5-bit arithmetic then never wraps for any 3-bit coordinate.
    always_comb begin
        r     = {2'b00, row};
        c     = {2'b00, col};
        d     = {1'b0, direction};
        k     = 5'd0;
        valid = 1'b0;
        if (direction == DOWN) begin
            valid = (r >= 5'd3);
        end else if (direction >= ROW_1 && direction <= ROW_4) begin
            k     = d - 5'd1;
            valid = (c + k >= 5'd4) && (c + k <= COLS_W);
        end else if (direction >= DIAG_RIGHT_UP_1 && direction <= DIAG_RIGHT_UP_4) begin
            k     = d - 5'd5;
            valid = (r + k >= 5'd4) && (r + k <= ROWS_W) &&
                    (c + k >= 5'd4) && (c + k <= COLS_W);
        end else if (direction >= DIAG_LEFT_DOWN_1 && direction <= DIAG_LEFT_DOWN_4) begin
            k     = d - 5'd9;
            valid = (r + k >= 5'd4) && (r + k <= ROWS_W) &&
                    (c + 5'd5 <= COLS_W + k) && (c + 5'd1 >= k);
        end
    end

endmodule

// File: rtl/win_check_sequencer.sv
// Walks the 13 line directions after a drop, issuing one checker transaction per on-board direction.
// 1 cycle per skipped direction, 2 + checker latency per issued one; new requests ignored while busy.
module win_check_sequencer
    import connect_four_pkg::*;
#(
    parameter int ROWS    = DEF_ROWS,
    parameter int COLS    = DEF_COLS,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   check_req,
    input  logic [2:0]             drop_row,
    input  logic [2:0]             drop_col,
    win_check_sequencer_if.master  dc,
    output logic                   busy,
    output logic                   done,
    output logic                   win,
    output logic [1:0]             winner,
    output logic [3:0]             win_dir,
    output logic                   timeout_err
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    seq_state_e      state;
    logic [3:0]      dir_idx;
    logic [WD_W-1:0] wdog;
    logic            dir_valid;

    direction_in_bounds #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_bounds (
        .row       (dc.dc_row),
        .col       (dc.dc_col),
        .direction (dir_idx),
        .valid     (dir_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            dir_idx         <= 4'd0;
            wdog            <= '0;
            dc.dc_start     <= 1'b0;
            dc.dc_row       <= 3'd0;
            dc.dc_col       <= 3'd0;
            dc.dc_direction <= 4'd0;
            busy            <= 1'b0;
            done            <= 1'b0;
            win             <= 1'b0;
            winner          <= 2'd0;
            win_dir         <= 4'd0;
            timeout_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (check_req) begin
                        dc.dc_row <= drop_row;
                        dc.dc_col <= drop_col;
                        dir_idx   <= DIR_FIRST;
                        win       <= 1'b0;
                        winner    <= 2'd0;
                        win_dir   <= 4'd0;
                        busy      <= 1'b1;
                        state     <= SELECT;
                    end
                end
                SELECT: begin
                    if (dir_idx > DIR_LAST) begin
                        win   <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (dir_valid) begin
                        dc.dc_start     <= 1'b1;
                        dc.dc_direction <= dir_idx;
                        state           <= START;
                    end else begin
                        dir_idx <= dir_idx + 4'd1;
                    end
                end
                START: begin
                    dc.dc_start <= 1'b0;
                    wdog        <= WD_W'(TIMEOUT);
                    state       <= WAIT;
                end
                WAIT: begin
                    wdog <= wdog - WD_W'(1);
                    if (dc.dc_finished) begin
                        if (dc.dc_winner != EMPTY) begin
                            win     <= 1'b1;
                            winner  <= dc.dc_winner;
                            win_dir <= dir_idx;
                            done    <= 1'b1;
                            state   <= DONE;
                        end else begin
                            dir_idx <= dir_idx + 4'd1;
                            state   <= SELECT;
                        end
                    end else if (wdog == WD_W'(1)) begin
                        // Last budgeted cycle passed without an answer.
                        timeout_err <= 1'b1;
                        win         <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_win_check_sequencer.sv
// Directed bench for win_check_sequencer with a behavioural direction checker and a start/result scoreboard.
module tb_win_check_sequencer;
    import connect_four_pkg::*;

    localparam int ROWS    = 6;
    localparam int COLS    = 7;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic       w;
        logic [1:0] p;
        logic [3:0] d;
    } res_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       check_req;
    logic [2:0] drop_row;
    logic [2:0] drop_col;
    logic       busy;
    logic       done;
    logic       win;
    logic [1:0] winner;
    logic [3:0] win_dir;
    logic       timeout_err;

    win_check_sequencer_if dc();

    win_check_sequencer #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .check_req   (check_req),
        .drop_row    (drop_row),
        .drop_col    (drop_col),
        .dc          (dc),
        .busy        (busy),
        .done        (done),
        .win         (win),
        .winner      (winner),
        .win_dir     (win_dir),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    int   exp_dirs[$];
    res_t exp_res[$];
    int   exp_r, exp_c;
    int   n_starts = 0, n_done = 0, start_cyc = 0, done_cyc = 0;

    bit         model_en = 1'b1;
    int         model_win_dir = 0;
    logic [1:0] model_win_val = 2'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Geometric model: walk the four cells of the line and test each one.
    function automatic bit in_board(input int r, input int c, input int d);
        int r0, c0, dr, dcl, k;
        r0 = r; c0 = c; dr = 0; dcl = 0;
        if (d == 1) begin
            dr = -1;
        end else if (d >= 2 && d <= 5) begin
            k = d - 1; c0 = c - 4 + k; dcl = 1;
        end else if (d >= 6 && d <= 9) begin
            k = d - 5; r0 = r - 4 + k; c0 = c - 4 + k; dr = 1; dcl = 1;
        end else if (d >= 10 && d <= 13) begin
            k = d - 9; r0 = r - 4 + k; c0 = c + 4 - k; dr = 1; dcl = -1;
        end else begin
            return 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            int rr, cc;
            rr = r0 + i * dr;
            cc = c0 + i * dcl;
            if (rr < 0 || rr > ROWS - 1 || cc < 0 || cc > COLS - 1) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Behavioural direction checker.
    bit m_w;
    int m_lat;
    initial begin
        dc.dc_finished = 1'b0;
        dc.dc_winner   = 2'd0;
        forever begin
            @(posedge clk); #1;
            if (dc.dc_start === 1'b1 && model_en) begin
                m_w   = (int'(dc.dc_direction) == model_win_dir);
                m_lat = m_w ? 10 : 6;
                repeat (m_lat - 2) @(posedge clk);
                #1;
                dc.dc_finished = 1'b1;
                dc.dc_winner   = m_w ? model_win_val : 2'd0;
                @(posedge clk); #1;
                dc.dc_finished = 1'b0;
                dc.dc_winner   = 2'd0;
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        int   d;
        res_t e;
        forever begin
            @(posedge clk); #1;
            if (dc.dc_start === 1'b1) begin
                n_starts++;
                start_cyc = cyc;
                check("start_expected", exp_dirs.size() > 0, 1);
                if (exp_dirs.size() > 0) begin
                    d = exp_dirs.pop_front();
                    check("dc_direction", dc.dc_direction, d);
                    check("dc_row", dc.dc_row, exp_r);
                    check("dc_col", dc.dc_col, exp_c);
                end
            end
            if (done === 1'b1) begin
                n_done++;
                done_cyc = cyc;
                check("done_expected", exp_res.size() > 0, 1);
                if (exp_res.size() > 0) begin
                    e = exp_res.pop_front();
                    check("win", win, e.w);
                    check("winner", winner, e.p);
                    check("win_dir", win_dir, e.d);
                end
            end
        end
    end

    task automatic run_req(input int r, input int c, input bit extra, input int r2, input int c2);
        bit   found;
        res_t e;
        int   nd;
        found = 1'b0;
        e.w = 1'b0; e.p = 2'd0; e.d = 4'd0;
        for (int d = 1; d <= 13; d++) begin
            if (!found && in_board(r, c, d)) begin
                exp_dirs.push_back(d);
                if (!model_en) begin
                    found = 1'b1;
                end else if (d == model_win_dir) begin
                    found = 1'b1;
                    e.w = 1'b1; e.p = model_win_val; e.d = 4'(d);
                end
            end
        end
        exp_res.push_back(e);
        exp_r = r; exp_c = c;
        nd = n_done;
        @(negedge clk);
        drop_row = 3'(r); drop_col = 3'(c); check_req = 1'b1;
        @(posedge clk); #1;
        check_req = 1'b0;
        check("busy_after_accept", busy, 1);
        if (extra) begin
            @(negedge clk);
            drop_row = 3'(r2); drop_col = 3'(c2); check_req = 1'b1;
            @(negedge clk);
            check_req = 1'b0;
        end
        for (int i = 0; i < 600 && n_done == nd; i++) begin
            @(posedge clk); #2;
        end
        check("done_within_budget", n_done - nd, 1);
        @(posedge clk); #1;
        check("busy_after_done", busy, 0);
        check("done_one_cycle", done, 0);
        check("all_starts_seen", exp_dirs.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish before time limit");
        $fatal(1);
    end

    initial begin
        int ns0, nd0;
        rst = 1'b1; check_req = 1'b0; drop_row = 3'd0; drop_col = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dc_start", dc.dc_start, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_win", win, 0);
        check("rst_winner", winner, 0);
        check("rst_win_dir", win_dir, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_dc_row", dc.dc_row, 0);
        check("rst_dc_col", dc.dc_col, 0);
        check("rst_dc_direction", dc.dc_direction, 0);
        @(negedge clk); rst = 1'b0;

        // Corner drop, no winner anywhere: only directions 5 and 9 fit.
        model_en = 1'b1; model_win_dir = 0; model_win_val = 2'd0;
        ns0 = n_starts;
        run_req(0, 0, 1'b0, 0, 0);
        check("corner_start_count", n_starts - ns0, 2);

        // Centre drop, player 2 wins on direction 3.
        model_win_dir = 3; model_win_val = 2'd2;
        ns0 = n_starts;
        run_req(3, 3, 1'b0, 0, 0);
        check("centre_start_count", n_starts - ns0, 3);

        // Top-right drop, no winner: directions 1, 2, 6.
        model_win_dir = 0; model_win_val = 2'd0;
        ns0 = n_starts;
        run_req(5, 6, 1'b0, 0, 0);
        check("topright_start_count", n_starts - ns0, 3);
        check("no_timeout_yet", timeout_err, 0);

        // Request while busy must be ignored; player 1 wins on direction 7.
        model_win_dir = 7; model_win_val = 2'd1;
        run_req(2, 4, 1'b1, 0, 6);
        check("held_dc_row", dc.dc_row, 2);
        check("held_dc_col", dc.dc_col, 4);

        // Checker never answers.
        model_en = 1'b0;
        ns0 = n_starts;
        run_req(0, 0, 1'b0, 0, 0);
        check("timeout_start_count", n_starts - ns0, 1);
        check("timeout_latency", done_cyc - start_cyc, TIMEOUT + 1);
        check("timeout_err_set", timeout_err, 1);
        check("timeout_win", win, 0);

        // Reset during WAIT.
        exp_r = 3; exp_c = 3;
        exp_dirs.push_back(1);
        ns0 = n_starts;
        @(negedge clk);
        drop_row = 3'd3; drop_col = 3'd3; check_req = 1'b1;
        @(negedge clk); check_req = 1'b0;
        for (int i = 0; i < 50 && n_starts == ns0; i++) begin
            @(posedge clk); #2;
        end
        check("rst_test_started", n_starts - ns0, 1);
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_dc_start", dc.dc_start, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_timeout_err", timeout_err, 0);
        check("midrst_win", win, 0);
        check("midrst_dc_row", dc.dc_row, 0);
        check("midrst_dc_col", dc.dc_col, 0);
        check("midrst_dc_direction", dc.dc_direction, 0);
        @(negedge clk); rst = 1'b0;
        nd0 = n_done; ns0 = n_starts;
        repeat (20) @(posedge clk);
        #1;
        check("midrst_no_done", n_done - nd0, 0);
        check("midrst_no_start", n_starts - ns0, 0);

        // Normal run after reset: player 1 wins straight down.
        model_en = 1'b1; model_win_dir = 1; model_win_val = 2'd1;
        run_req(3, 3, 1'b0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/win_check_sequencer.md
# win_check_sequencer

Control stage directly upstream of `direction_checker`. After every piece drop it walks the 13 line directions in ascending code order and skips any direction whose four cells leave the board. For each remaining direction it issues one `start`/`finished_checking` transaction. It stops at the first direction that reports a non-empty winner and reports a single win/no-win result to the game FSM.

## Interface
Parameters:
- `ROWS`, 6, board rows; row 0 is the bottom.
- `COLS`, 7, board columns.
- `TIMEOUT`, 16, maximum cycles to wait for `dc_finished` after a start.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `check_req`  in  1  request a win check; accepted only when `busy`=0.
- `drop_row`  in  3  row of the dropped piece; sampled on accept.
- `drop_col`  in  3  column of the dropped piece; sampled on accept.
- `dc_start`  out  1  start pulse to `direction_checker`.
- `dc_row`, `dc_col`  out  3 each  latched drop coordinates.
- `dc_direction`  out  4  current direction code, 1..13.
- `dc_finished`  in  1  `finished_checking` from the checker.
- `dc_winner`  in  2  `winner` from the checker.
- `busy`  out  1  high from accept until `done`.
- `done`  out  1  one-cycle result pulse.
- `win`  out  1  1 if a winning direction was found.
- `winner`  out  2  winning player code; 0 when there is no win.
- `win_dir`  out  4  winning direction code; 0 when there is no win.
- `timeout_err`  out  1  sticky flag: the checker failed to finish within `TIMEOUT`.

## Operation
- States: IDLE, SELECT, START, WAIT, DONE.
- IDLE:
  - On `check_req`, latch `drop_row`/`drop_col`, set `dir_idx`=1, clear `win`/`winner`/`win_dir`, and go to SELECT.
  - `check_req` is ignored in every other state.
- SELECT (one direction evaluated per cycle):
  - If `dir_idx` > 13, go to DONE with `win`=0.
  - Else if the direction is in bounds, go to START.
  - Else increment `dir_idx` and stay in SELECT.
- START: `dc_start`=1 for exactly this cycle. Load the watchdog with `TIMEOUT`. Go to WAIT.
- WAIT:
  - Decrement the watchdog each cycle.
  - On `dc_finished`=1 with `dc_winner`≠0: latch `win`=1, `winner`=`dc_winner`, `win_dir`=`dir_idx`, and go to DONE.
  - On `dc_finished`=1 with `dc_winner`=0: treat as no win, increment `dir_idx`, and go to SELECT.
  - If the watchdog reaches 0 first: set `timeout_err`, set `win`=0, and go to DONE.
- DONE: `done`=1 for one cycle, then IDLE. `win`/`winner`/`win_dir` hold until the next accepted request.
- Bounds rules (r = row, c = col); all four cells must satisfy 0 ≤ row ≤ ROWS-1 and 0 ≤ col ≤ COLS-1:
  - DOWN (1): r ≥ 3.
  - ROW_k (2..5, k=1..4): c ≥ 4-k and c+k-1 ≤ COLS-1.
  - DIAG_RIGHT_UP_k (6..9): r ≥ 4-k, r+k-1 ≤ ROWS-1, c ≥ 4-k, c+k-1 ≤ COLS-1.
  - DIAG_LEFT_DOWN_k (10..13): the same row rule; c+4-k ≤ COLS-1 and c ≥ k-1.
- Bounds arithmetic is unsigned at 4 bits or wider. No 3-bit wrap is permitted; the checker itself wraps modulo 8, which is why out-of-board directions must never be issued.
- `timeout_err` is cleared only by `rst`.

## Timing
- Reset values:
  - State IDLE; all outputs 0, including `dc_start`, `busy`, `done`, `win`, `winner`, `win_dir` and `timeout_err`.
  - `dc_row`/`dc_col` 0; `dc_direction` 0.
- Reset asserted mid-check: return to IDLE on the next edge and drop `dc_start` immediately; no `done` pulse is produced.
- `busy` rises the cycle after `check_req` is accepted and falls in the cycle after `done`.
- `dc_row`, `dc_col` and `dc_direction` are stable from START through the end of WAIT. The checker reads them combinationally during its write-back states.
- Per issued direction: 1 SELECT + 1 START + checker latency (6 cycles with no win, 10 with a win). Each skipped direction costs 1 cycle.
- A `dc_finished` that arrives outside WAIT is ignored.

## Structure
- Shared package `connect_four_pkg`:
  - direction codes DOWN..DIAG_LEFT_DOWN_4, with DIR_FIRST=1 and DIR_LAST=13;
  - player codes EMPTY=0, P1=1, P2=2;
  - default board dimensions.
- One sub-module: `direction_in_bounds`, purely combinational. Inputs are row, col and direction; the output is `valid`. It is parameterised by `ROWS`/`COLS`.

## Test plan
- Drop at (0,0) with the checker model always returning winner 0 → exactly two `dc_start` pulses, with `dc_direction` 5 then 9; then `done`, `win`=0.
- Drop at (3,3) with the model returning winner 2 on direction 3 → starts for directions 1, 2, 3 only; then `done`, `win`=1, `winner`=2, `win_dir`=3.
- The model returns `dc_finished` with winner 0 on every direction for a drop at (5,6) → no spurious win; every issued direction passes the bounds rules.
- The model never asserts `dc_finished` → `timeout_err`=1 and `done` exactly `TIMEOUT`+1 cycles after the `dc_start` pulse; `win`=0.
- `check_req` pulsed while `busy` with different coordinates → ignored; `dc_row`/`dc_col` stay at the first request's values.
- `rst` asserted during WAIT → next cycle all outputs are 0 and the state is IDLE; a following request then runs normally.
